// File: rtl/serial_adder_seq_pkg.sv
// serial_adder_seq_pkg: state encoding shared by the bit-serial adder.
package serial_adder_seq_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/fa_ha_str.sv
// fa_ha_str: gate-level one-bit full adder.
module fa_ha_str (
    output logic s,
    output logic c,
    input  logic a,
    input  logic b,
    input  logic cin
);
    logic w_p, w_g, w_t;
    xor g_p (w_p, a, b);
    xor g_s (s, w_p, cin);
    and g_g (w_g, a, b);
    and g_t (w_t, w_p, cin);
    or  g_c (c, w_g, w_t);
endmodule

// File: rtl/serial_adder_seq.sv
// serial_adder_seq: bit-serial adder, one full-adder cell plus carry flop, LSB first.
module serial_adder_seq
    import serial_adder_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH);
    state_t r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_s, r_sum;
    logic [CW-1:0] r_cnt;
    logic r_carry, r_cout, w_s, w_c, w_last;
    fa_ha_str u_fa (.s(w_s), .c(w_c), .a(r_a[0]), .b(r_b[0]), .cin(r_carry));
    assign w_last = r_cnt == CW'(WIDTH - 1);
    assign busy = r_state == SHIFT;
    assign done = r_state == DONE;
    assign sum = r_sum;
    assign cout = r_cout;
    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:    w_next = start ? SHIFT : IDLE;
            SHIFT:   w_next = w_last ? DONE : SHIFT;
            DONE:    w_next = start ? SHIFT : IDLE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a <= '0;
            r_b <= '0;
            r_s <= '0;
            r_sum <= '0;
            r_cnt <= '0;
            r_carry <= 1'b0;
            r_cout <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == SHIFT) begin
                r_a <= r_a >> 1;
                r_b <= r_b >> 1;
                r_s <= {w_s, r_s[WIDTH-1:1]};
                r_carry <= w_c;
                // wrap to 0 on the last bit so the counter never passes WIDTH-1
                r_cnt <= w_last ? '0 : r_cnt + CW'(1);
                if (w_last) begin
                    r_sum <= {w_s, r_s[WIDTH-1:1]};
                    r_cout <= w_c;
                end
            end else if (start) begin
                r_a <= a_in;
                r_b <= b_in;
                r_carry <= cin;
                r_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_serial_adder_seq.sv
// tb_serial_adder_seq: directed vector table plus corner sequences for the serial adder.
module tb_serial_adder_seq;
    logic clk, rst_n;
    logic start, cin, busy, done, cout;
    logic [7:0] a_in, b_in, sum;
    logic start2, cin2, busy2, done2, cout2;
    logic [1:0] a2, b2, sum2;
    int checks = 0, failures = 0;

    serial_adder_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );
    serial_adder_seq #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a_in(a2), .b_in(b2), .cin(cin2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [7:0] s;
        logic       co;
    } vec_t;
    vec_t vecs [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 0;
        while (done !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int pulses;
        logic [7:0] prev;
        vecs[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vecs[7] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
        vecs[8] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
        vecs[9] = '{8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1};
        rst_n = 1'b0;
        start = 1'b0; a_in = '0; b_in = '0; cin = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
        #1;
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_sum", 32'(sum), 0);
        check("reset_cout", 32'(cout), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            prev = sum;
            a_in = vecs[i].a; b_in = vecs[i].b; cin = vecs[i].c; start = 1'b1;
            tick();
            start = 1'b0; a_in = ~a_in; b_in = 8'h5C; cin = ~cin;
            check("busy_after_start", 32'(busy), 1);
            tick();
            check("sum_held_mid_op", 32'(sum), 32'(prev));
            wait_done(20, n);
            check("latency", 32'(n + 1), 8);
            check("vec_sum", 32'(sum), 32'(vecs[i].s));
            check("vec_cout", 32'(cout), 32'(vecs[i].co));
            check("busy_in_done", 32'(busy), 0);
            tick();
            check("done_one_cycle", 32'(done), 0);
            check("idle_after_done", 32'(busy), 0);
        end

        // back-to-back: start held high through SHIFT and into DONE
        a_in = 8'hFF; b_in = 8'hFF; cin = 1'b1; start = 1'b1;
        tick();
        a_in = 8'h01; b_in = 8'h02; cin = 1'b0;
        wait_done(20, n);
        check("b2b_latency", 32'(n), 8);
        check("b2b_first_sum", 32'(sum), 32'hFF);
        check("b2b_first_cout", 32'(cout), 1);
        tick();
        start = 1'b0;
        check("b2b_done_drops", 32'(done), 0);
        check("b2b_busy_again", 32'(busy), 1);
        check("b2b_sum_held", 32'(sum), 32'hFF);
        wait_done(20, n);
        check("b2b_second_latency", 32'(n), 8);
        check("b2b_second_sum", 32'(sum), 32'h03);
        check("b2b_second_cout", 32'(cout), 0);
        tick();

        // start pulse mid-SHIFT with other operands is ignored
        a_in = 8'h5A; b_in = 8'h33; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        a_in = 8'h11; b_in = 8'h22; cin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(20, n);
        check("ignore_latency", 32'(n + 4), 8);
        check("ignore_sum", 32'(sum), 32'h8D);
        check("ignore_cout", 32'(cout), 0);
        tick();

        // async reset three cycles into an op
        a_in = 8'hFF; b_in = 8'h01; cin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_sum", 32'(sum), 0);
        check("abort_cout", 32'(cout), 0);
        tick(); tick();
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1) pulses++;
        end
        check("abort_no_done", 32'(pulses), 0);
        check("abort_sum_after", 32'(sum), 0);

        // WIDTH=2 exhaustive sweep
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                for (int c = 0; c < 2; c++) begin
                    a2 = 2'(a); b2 = 2'(b); cin2 = 1'(c); start2 = 1'b1;
                    tick();
                    start2 = 1'b0;
                    n = 0;
                    while (done2 !== 1'b1 && n < 10) begin
                        tick();
                        n++;
                    end
                    check("w2_latency", 32'(n), 2);
                    check($sformatf("w2_%0d_%0d_%0d", a, b, c), 32'({cout2, sum2}), 32'(a + b + c));
                    tick();
                end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
